// File: rtl/isp_pkg.sv
// Shared constants and state type for the auto-focus gray crop block.
// Geometry is fixed: 32x32x3 picture in 128-bit beats, 6x6 centre crop.
package isp_pkg;

    localparam int DATA_W          = 128;
    localparam int IMG_W           = 32;
    localparam int CROP            = 6;
    localparam int CROP_OFS        = 13;
    localparam int CROP_PIX        = CROP * CROP;
    localparam int BEATS           = 192;
    localparam int BEATS_PER_PLANE = 64;
    localparam int PIX_PER_BEAT    = 16;

    // Per-channel right shifts forming R/4 + G/2 + B/4.
    localparam int SHIFT_R = 2;
    localparam int SHIFT_G = 1;
    localparam int SHIFT_B = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

endpackage

// File: rtl/isp_gray_lane.sv
// Extracts the three crop-window pixels carried by one beat half and applies
// the channel weight shift.
module isp_gray_lane
    import isp_pkg::*;
(
    input  logic [DATA_W-1:0] beat_data,
    input  logic              half,
    input  logic [1:0]        ch,
    output logic [2:0][7:0]   px
);

    // Left half of a row holds crop cols 0..2 at pixels 13..15; the right half
    // holds crop cols 3..5 at pixels 0..2.
    localparam int BASE_LO = CROP_OFS;
    localparam int BASE_HI = CROP_OFS + CROP / 2 - PIX_PER_BEAT;

    function automatic logic [7:0] weigh(input logic [7:0] p, input logic [1:0] c);
        case (c)
            2'd0:    return p >> SHIFT_R;
            2'd1:    return p >> SHIFT_G;
            default: return p >> SHIFT_B;
        endcase
    endfunction

    logic [4:0] pix_base;

    always_comb begin
        pix_base = half ? 5'(BASE_HI) : 5'(BASE_LO);
        px       = '0;
        for (int j = 0; j < 3; j++) begin
            px[j] = weigh(beat_data[8 * (int'(pix_base) + j) +: 8], ch);
        end
    end

endmodule

// File: rtl/isp_af_gray_crop.sv
// Accumulates the centre 6x6 gray window from a 3-plane read burst, then
// streams the 36 gray pixels in raster order.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; buffer cleared when start is taken
// RECV    | accepting 192 beats, accumulating weighted crop pixels
// EMIT    | presenting buf[gray_idx] until all 36 pixels are handshaken
module isp_af_gray_crop
    import isp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              beat_valid,
    input  logic [DATA_W-1:0] beat_data,
    input  logic              beat_last,
    output logic              beat_ready,
    output logic              gray_valid,
    input  logic              gray_ready,
    output logic [7:0]        gray_data,
    output logic [5:0]        gray_idx,
    output logic              gray_last,
    output logic              busy,
    output logic              done,
    output logic              proto_err
);

    state_t     state, state_nx;
    logic [7:0] beat_cnt;
    logic [5:0] gray_idx_q;
    logic       done_q;
    logic       proto_err_q;
    logic [7:0] pix_buf [CROP_PIX];

    logic [1:0]      ch;
    logic [4:0]      row;
    logic [4:0]      row_ofs;
    logic            half;
    logic            in_win;
    logic [5:0]      base;
    logic            accept;
    logic            last_beat;
    logic            emit_hs;
    logic            final_hs;
    logic [2:0][7:0] lane_px;

    assign ch        = beat_cnt[7:6];
    assign row       = beat_cnt[5:1];
    assign half      = beat_cnt[0];
    assign in_win    = (row >= 5'(CROP_OFS)) && (row < 5'(CROP_OFS + CROP));
    assign row_ofs   = row - 5'(CROP_OFS);
    assign base      = 6'(row_ofs) * 6'(CROP) + (half ? 6'(CROP / 2) : 6'd0);
    assign accept    = (state == ST_RECV) && beat_valid;
    assign last_beat = (beat_cnt == 8'(BEATS - 1));
    assign emit_hs   = (state == ST_EMIT) && gray_ready;
    assign final_hs  = emit_hs && (gray_idx_q == 6'(CROP_PIX - 1));

    isp_gray_lane u_lane (
        .beat_data (beat_data),
        .half      (half),
        .ch        (ch),
        .px        (lane_px)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start)                state_nx = ST_RECV;
            ST_RECV: if (accept && last_beat)  state_nx = ST_EMIT;
            ST_EMIT: if (final_hs)             state_nx = ST_IDLE;
            default:                           state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt    <= '0;
            gray_idx_q  <= '0;
            done_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            done_q <= final_hs;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        beat_cnt    <= '0;
                        gray_idx_q  <= '0;
                        proto_err_q <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        // Sticky: the count, not rlast, ends the burst.
                        if (beat_last != last_beat) begin
                            proto_err_q <= 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (emit_hs) begin
                        gray_idx_q <= final_hs ? 6'd0 : gray_idx_q + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Buffer has no reset; every picture starts by clearing it on start.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) begin
            for (int i = 0; i < CROP_PIX; i++) begin
                pix_buf[i] <= '0;
            end
        end else if (accept && in_win) begin
            for (int j = 0; j < 3; j++) begin
                pix_buf[base + 6'(j)] <= pix_buf[base + 6'(j)] + lane_px[j];
            end
        end
    end

    assign beat_ready = (state == ST_RECV);
    assign gray_valid = (state == ST_EMIT);
    assign gray_data  = gray_valid ? pix_buf[gray_idx_q] : 8'd0;
    assign gray_idx   = gray_idx_q;
    assign gray_last  = gray_valid && (gray_idx_q == 6'(CROP_PIX - 1));
    assign busy       = (state != ST_IDLE);
    assign done       = done_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_isp_af_gray_crop.sv
// Self-checking bench for isp_af_gray_crop: picture table, scoreboard queue
// filled from an independent gray model, plus reset and restart sequences.
module tb_isp_af_gray_crop;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         beat_valid;
    logic [127:0] beat_data;
    logic         beat_last;
    logic         beat_ready;
    logic         gray_valid;
    logic         gray_ready;
    logic [7:0]   gray_data;
    logic [5:0]   gray_idx;
    logic         gray_last;
    logic         busy;
    logic         done;
    logic         proto_err;

    isp_af_gray_crop dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .beat_valid (beat_valid),
        .beat_data  (beat_data),
        .beat_last  (beat_last),
        .beat_ready (beat_ready),
        .gray_valid (gray_valid),
        .gray_ready (gray_ready),
        .gray_data  (gray_data),
        .gray_idx   (gray_idx),
        .gray_last  (gray_last),
        .busy       (busy),
        .done       (done),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pat;        // 0 all 0xFF, 1 planes 40/80/40, 2 column ramp, 3 random
        bit stall;      // random beat gaps and gray_ready stalls
        int last_at;    // beat carrying beat_last
        int restart_at; // beat at which a (to be ignored) start is pulsed, -1 none
        int rst_at;     // beat at which reset is pulsed, -1 none
        int exp_g0;     // known first gray value, -1 if not fixed
        bit exp_err;
    } vec_t;

    vec_t         vecs [9];
    logic [127:0] pic  [192];
    int           exp_q [$];
    int           n_vec = 0;
    int           n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic build_pic(input int pat);
        for (int b = 0; b < 192; b++) begin
            for (int k = 0; k < 16; k++) begin
                int ch, col;
                logic [7:0] v;
                ch  = b / 64;
                col = (b % 2) * 16 + k;
                case (pat)
                    0:       v = 8'hFF;
                    1:       v = (ch == 1) ? 8'h80 : 8'h40;
                    2:       v = 8'(col);
                    default: v = 8'($urandom_range(0, 255));
                endcase
                pic[b][8*k +: 8] = v;
            end
        end
    endtask

    function automatic int pix_at(input int ch, input int row, input int col);
        logic [127:0] w;
        w = pic[ch * 64 + row * 2 + col / 16];
        return int'(w[8 * (col % 16) +: 8]);
    endfunction

    task automatic model_push();
        exp_q.delete();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                exp_q.push_back(pix_at(0, 13 + r, 13 + c) / 4 +
                                pix_at(1, 13 + r, 13 + c) / 2 +
                                pix_at(2, 13 + r, 13 + c) / 4);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_beat_ready"}, 32'(beat_ready), 0);
        check({tag, "_gray_valid"}, 32'(gray_valid), 0);
        check({tag, "_gray_data"},  32'(gray_data),  0);
        check({tag, "_gray_idx"},   32'(gray_idx),   0);
        check({tag, "_gray_last"},  32'(gray_last),  0);
        check({tag, "_busy"},       32'(busy),       0);
        check({tag, "_done"},       32'(done),       0);
        check({tag, "_proto_err"},  32'(proto_err),  0);
    endtask

    task automatic run_picture(input vec_t v);
        int   bptr = 0, hs_cnt = 0, exp_val;
        bit   stall_prev = 0, expect_done = 0, finished = 0, chk_err = 0, restarted = 0, rst_now = 0;
        logic [7:0] held_data;
        logic [5:0] held_idx;

        build_pic(v.pat);
        model_push();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_proto_err_clear", 32'(proto_err), 0);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (stall_prev) begin
                check("stall_valid", 32'(gray_valid), 1);
                check("stall_data",  32'(gray_data),  32'(held_data));
                check("stall_idx",   32'(gray_idx),   32'(held_idx));
            end
            if (expect_done) begin
                check("done_pulse", 32'(done), 1);
                check("done_idle",  32'(busy), 0);
                check("proto_err_end", 32'(proto_err), 32'(v.exp_err));
                @(negedge clk);
                check("done_one_cycle", 32'(done), 0);
                finished = 1;
                break;
            end
            check("done_early", 32'(done), 0);

            start = (bptr == v.restart_at) && !restarted;
            if (start) restarted = 1;
            if (bptr < 192) begin
                beat_valid = v.stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                beat_data  = pic[bptr];
                beat_last  = (bptr == v.last_at);
            end else begin
                beat_valid = 1'b0;
                beat_last  = 1'b0;
            end
            gray_ready = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;

            if (gray_valid && gray_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_output", 1, 0);
                end else begin
                    exp_val = exp_q.pop_front();
                    check("gray_data", 32'(gray_data), 32'(exp_val));
                    check("gray_idx",  32'(gray_idx),  32'(hs_cnt));
                    check("gray_last", 32'(gray_last), 32'(hs_cnt == 35));
                    if (hs_cnt == 0 && v.exp_g0 >= 0)
                        check("gray_first_known", 32'(gray_data), 32'(v.exp_g0));
                end
                hs_cnt++;
                if (hs_cnt == 36) expect_done = 1;
            end
            stall_prev = gray_valid && !gray_ready;
            held_data  = gray_data;
            held_idx   = gray_idx;

            if (beat_valid && beat_ready) begin
                if (bptr == v.last_at && v.last_at != 191) chk_err = 1;
                if (bptr == v.rst_at) begin
                    rst_n   = 1'b0;
                    rst_now = 1;
                end
                bptr++;
            end
            @(negedge clk);
            start = 1'b0;
            if (rst_now) begin
                rst_n      = 1'b1;
                beat_valid = 1'b0;
                check_idle_outputs("mid_reset");
                return;
            end
            if (chk_err) begin
                check("proto_err_set", 32'(proto_err), 1);
                check("busy_after_err", 32'(busy), 1);
                chk_err = 0;
            end
        end
        beat_valid = 1'b0;
        gray_ready = 1'b0;
        if (!finished) check("picture_timeout", 0, 1);
        check("queue_drained", 32'(exp_q.size()), 0);
    endtask

    initial begin
        vecs[0] = '{0, 0, 191, -1,  -1, 253, 0};
        vecs[1] = '{1, 0, 191, -1,  -1,  96, 0};
        vecs[2] = '{2, 0, 191, -1,  -1,  12, 0};
        vecs[3] = '{2, 1, 191, -1,  -1,  12, 0};
        vecs[4] = '{0, 0, 100, -1,  -1, 253, 1};
        vecs[5] = '{1, 1, 191, 50,  -1,  96, 0};
        vecs[6] = '{0, 0, 191, -1, 150,  -1, 0};
        vecs[7] = '{0, 0, 191, -1,  -1, 253, 0};
        vecs[8] = '{3, 1, 191, -1,  -1,  -1, 0};

        rst_n      = 1'b0;
        start      = 1'b0;
        beat_valid = 1'b0;
        beat_data  = '0;
        beat_last  = 1'b0;
        gray_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        for (int i = 0; i < 9; i++) begin
            run_picture(vecs[i]);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
